// File: rtl/ps2_key_tracker_pkg.sv
// Shared PS/2 keyboard constants, decoder state encoding and game key codes.
// Imported by the key tracker and anything that consumes its key_down bitmap.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Keyboard-to-host replies that never carry key information
  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_ERR_00   = 8'h00;
  localparam logic [7:0] PS2_ERR_FF   = 8'hFF;

  localparam logic [8:0] KEY_W     = 9'h01D;
  localparam logic [8:0] KEY_A     = 9'h01C;
  localparam logic [8:0] KEY_S     = 9'h01B;
  localparam logic [8:0] KEY_D     = 9'h023;
  localparam logic [8:0] KEY_UP    = 9'h175;
  localparam logic [8:0] KEY_DOWN  = 9'h172;
  localparam logic [8:0] KEY_LEFT  = 9'h16B;
  localparam logic [8:0] KEY_RIGHT = 9'h174;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } ps2_state_t;

  typedef struct packed {
    logic       vld;
    logic       brk;
    logic [8:0] code;
  } key_evt_t;

  function automatic logic is_reply(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
           (b == PS2_BAT_FAIL) || (b == PS2_RESEND) ||
           (b == PS2_ERR_00) || (b == PS2_ERR_FF);
  endfunction

endpackage

// File: rtl/ps2_seq_timer.sv
// Idle-cycle counter for an unfinished scan-code sequence; pulses expire on the
// cycle the count reaches TIMEOUT_CYC so the decoder can drop the sequence.
module ps2_seq_timer #(
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 set-2 bytes (E0 / F0 / E1 prefixes) into a held-key bitmap and a
// registered one-cycle change event, one cycle after the completing byte.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned KEY_BITS    = 512,
  parameter int unsigned TIMEOUT_CYC = 2000000,
  parameter int unsigned PAUSE_SKIP  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                rx_err,
  input  logic                clear_keys,
  output logic [KEY_BITS-1:0] key_down,
  output logic [8:0]          last_change,
  output logic                been_ready,
  output logic                key_break
);

  localparam int SKW = (PAUSE_SKIP > 1) ? $clog2(PAUSE_SKIP) : 1;

  ps2_state_t     state, state_nxt;
  logic [SKW-1:0] skip_cnt, skip_nxt;
  key_evt_t       evt;
  logic           tmo_clear, tmo_en, tmo_expire;
  logic [KEY_BITS-1:0] key_nxt;

  // The timer only runs while a sequence is open and the line is quiet
  assign tmo_clear = rx_valid || rx_err || (state == ST_IDLE);
  assign tmo_en    = !tmo_clear;

  ps2_seq_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmo_clear),
    .en    (tmo_en),
    .expire(tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    evt       = '0;
    if (rx_err) begin
      state_nxt = ST_IDLE;
    end else if (rx_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (rx_data == PS2_EXT) begin
            state_nxt = ST_EXT;
          end else if (rx_data == PS2_BRK) begin
            state_nxt = ST_BRK;
          end else if (rx_data == PS2_PAUSE) begin
            state_nxt = ST_SKIP;
            skip_nxt  = '0;
          end else if (!is_reply(rx_data)) begin
            evt = '{vld: 1'b1, brk: 1'b0, code: {1'b0, rx_data}};
          end
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else if (rx_data != PS2_EXT) begin
            evt       = '{vld: 1'b1, brk: 1'b0, code: {1'b1, rx_data}};
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (rx_data != PS2_BRK) begin
            evt       = '{vld: 1'b1, brk: 1'b1, code: {1'b0, rx_data}};
            state_nxt = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          evt       = '{vld: 1'b1, brk: 1'b1, code: {1'b1, rx_data}};
          state_nxt = ST_IDLE;
        end
        ST_SKIP: begin
          if (skip_cnt == SKW'(PAUSE_SKIP - 1)) begin
            state_nxt = ST_IDLE;
          end else begin
            skip_nxt = skip_cnt + 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (tmo_expire) begin
      state_nxt = ST_IDLE;
    end
  end

  // A clear and a completing make in the same cycle: clear first, then the make lands
  always_comb begin
    key_nxt = clear_keys ? '0 : key_down;
    if (evt.vld && (32'(evt.code) < KEY_BITS)) begin
      key_nxt[evt.code] = !evt.brk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_down    <= '0;
      last_change <= '0;
      been_ready  <= 1'b0;
      key_break   <= 1'b0;
    end else begin
      key_down   <= key_nxt;
      been_ready <= evt.vld;
      if (evt.vld) begin
        last_change <= evt.code;
        key_break   <= evt.brk;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed scenarios with literal expectations, then
// randomized byte traffic compared every cycle against a prefix-flag model.
module tb_ps2_key_tracker;

  localparam int KB = 512;
  localparam int TO = 40;
  localparam int PS = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_err = 1'b0;
  logic          clear_keys = 1'b0;
  logic [KB-1:0] key_down;
  logic [8:0]    last_change;
  logic          been_ready;
  logic          key_break;

  always #5 clk = ~clk;

  ps2_key_tracker #(
    .KEY_BITS(KB),
    .TIMEOUT_CYC(TO),
    .PAUSE_SKIP(PS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .clear_keys (clear_keys),
    .key_down   (key_down),
    .last_change(last_change),
    .been_ready (been_ready),
    .key_break  (key_break)
  );

  // Model: which prefixes have been seen, bytes left to swallow, quiet cycles
  bit            m_ext, m_brk;
  int            m_skip, m_quiet;
  logic [KB-1:0] m_kd;
  logic [8:0]    m_last;
  bit            m_rdy, m_kbrk;

  int n_chk = 0;
  int n_pass = 0;
  int rdy_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [KB-1:0] act, input logic [KB-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic bit reply_byte(input logic [7:0] b);
    return b inside {8'hFA, 8'hAA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF};
  endfunction

  task automatic drop_seq();
    m_ext = 0; m_brk = 0; m_skip = 0; m_quiet = 0;
  endtask

  task automatic model_step();
    bit         fire = 0;
    bit         fbrk = 0;
    logic [8:0] fcode = '0;
    if (rst) begin
      drop_seq();
      m_kd = '0; m_last = '0; m_rdy = 0; m_kbrk = 0;
      return;
    end
    if (rx_err) begin
      drop_seq();
    end else if (rx_valid) begin
      m_quiet = 0;
      if (m_skip > 0) begin
        m_skip--;
      end else if (m_ext && m_brk) begin
        fire = 1; fbrk = 1; fcode = {1'b1, rx_data}; drop_seq();
      end else if (m_brk) begin
        if (rx_data != 8'hF0) begin
          fire = 1; fbrk = 1; fcode = {1'b0, rx_data}; drop_seq();
        end
      end else if (m_ext) begin
        if (rx_data == 8'hF0) m_brk = 1;
        else if (rx_data != 8'hE0) begin
          fire = 1; fcode = {1'b1, rx_data}; drop_seq();
        end
      end else if (rx_data == 8'hE0) m_ext = 1;
      else if (rx_data == 8'hF0) m_brk = 1;
      else if (rx_data == 8'hE1) m_skip = PS;
      else if (!reply_byte(rx_data)) begin
        fire = 1; fcode = {1'b0, rx_data};
      end
    end else if (m_ext || m_brk || m_skip > 0) begin
      m_quiet++;
      if (m_quiet >= TO) drop_seq();
    end
    if (clear_keys) m_kd = '0;
    if (fire) begin
      m_kd[fcode] = !fbrk;
      m_last = fcode;
      m_kbrk = fbrk;
    end
    m_rdy = fire;
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit e = 1'b0,
                     input bit c = 1'b0, input bit r = 1'b0);
    rx_valid = v; rx_data = d; rx_err = e; clear_keys = c; rst = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("key_down", key_down, m_kd);
      chk("last_change", last_change, m_last);
      chk("been_ready", been_ready, m_rdy);
      chk("key_break", key_break, m_kbrk);
      if (been_ready === 1'b1) rdy_cnt++;
    end
  end

  logic [7:0] tbl [16] = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'h1D,
                           8'h1C, 8'h1B, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h12};

  initial begin
    int p0;
    logic [KB-1:0] only;
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    chk_en = 1'b1;
    idle(1);
    chk("rst_key_down", key_down, '0);
    chk("rst_last_change", last_change, 9'h000);
    chk("rst_been_ready", been_ready, 1'b0);

    // make
    send(8'h1D);
    chk("t1_kd01D", key_down[9'h01D], 1'b1);
    chk("t1_last", last_change, 9'h01D);
    chk("t1_rdy", been_ready, 1'b1);
    chk("t1_brk", key_break, 1'b0);
    idle(1);
    chk("t1_rdy_low", been_ready, 1'b0);

    // break
    p0 = rdy_cnt;
    send(8'hF0); send(8'h1D); idle(2);
    chk("t2_kd01D", key_down[9'h01D], 1'b0);
    chk("t2_last", last_change, 9'h01D);
    chk("t2_brk", key_break, 1'b1);
    chk("t2_pulses", rdy_cnt - p0, 1);

    // extended make / break
    send(8'hE0); send(8'h75);
    chk("t3_kd175_set", key_down[9'h175], 1'b1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t3_kd175_clr", key_down[9'h175], 1'b0);
    chk("t3_kd075", key_down[9'h075], 1'b0);
    chk("t3_last", last_change, 9'h175);

    // pause swallowed
    idle(1);
    p0 = rdy_cnt;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    idle(2);
    chk("t4_pulses", rdy_cnt - p0, 0);
    send(8'h23);
    chk("t4_kd023", key_down[9'h023], 1'b1);
    chk("t4_last", last_change, 9'h023);

    // timeout boundary
    send(8'hF0); idle(TO); send(8'h1C);
    chk("t5_kd01C", key_down[9'h01C], 1'b1);
    chk("t5_brk", key_break, 1'b0);
    send(8'hF0); idle(TO - 1); send(8'h1C);
    chk("t5_early_kd01C", key_down[9'h01C], 1'b0);
    chk("t5_early_brk", key_break, 1'b1);

    // clear_keys with a completing make
    send(8'h1D); idle(2);
    p0 = rdy_cnt;
    cyc(1, 8'h1C, 0, 1);
    only = '0;
    only[9'h01C] = 1'b1;
    chk("t6_only01C", key_down, only);
    idle(2);
    chk("t6_pulses", rdy_cnt - p0, 1);

    // replies and errors: no pulses
    p0 = rdy_cnt;
    send(8'hFA); send(8'hAA); send(8'hF0);
    cyc(0, 8'h00, 1); send(8'hE0);
    cyc(1, 8'h1D, 1); idle(2);
    chk("t6_quiet", rdy_cnt - p0, 0);
    chk("t6_kd_kept", key_down, only);
    send(8'h1D);
    chk("t6_after_err", key_down[9'h01D], 1'b1);
    chk("t6_after_err_brk", key_break, 1'b0);
    cyc(0, 8'h00, 0, 1);
    chk("clear_only", key_down, '0);
    chk("clear_no_rdy", been_ready, 1'b0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 199);
      b = tbl[$urandom_range(0, 15)];
      if ($urandom_range(0, 9) == 0) b = 8'($urandom);
      if (r < 1) cyc(0, 8'h00, 0, 0, 1);
      else if (r < 4) cyc($urandom_range(0, 1) == 1, b, 1);
      else if (r < 7) cyc($urandom_range(0, 1) == 1, b, 0, 1);
      else if (r < 80) send(b);
      else if (r < 196) idle(1);
      else idle(TO - 2 + $urandom_range(0, 3));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
